// File: rtl/serial_frame_pkg.sv
// Shared types and default timing for the serial frame sender.
package serial_frame_pkg;

  // Transmit sequencer states
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_LATCH = 3'd1,
    ST_WAIT_SEND  = 3'd2,
    ST_SHIFT      = 3'd3,
    ST_HOLDOFF    = 3'd4
  } state_t;

  // Defaults for a 10 MHz clock
  localparam int DEF_DATA_W    = 12;
  localparam int DEF_LATCH_DLY = 8000;     // 0.8 ms
  localparam int DEF_SEND_DLY  = 10000;    // 1 ms
  localparam int DEF_HOLDOFF   = 5000000;  // 0.5 s
  localparam int DEF_BIT_CYC   = 1;

  // Number of bits on the wire: payload plus optional parity bit
  function automatic int frame_w(input int data_w, input int parity_en);
    return data_w + ((parity_en != 0) ? 1 : 0);
  endfunction

endpackage

// File: rtl/serial_frame_sender_trigger_edge_sync.sv
// Trigger synchroniser with arm-after-low qualification and a one-clock
// rising-edge pulse.
module trigger_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic trig_async,
  output logic edge_pulse
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic armed_q;

  // Two-flop synchroniser, previous-value flop and arm flag. The sync chain
  // resets high so that a trigger held high through reset release is never
  // mistaken for a low sample; arming needs a genuine low from the pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      armed_q <= 1'b0;
    end else begin
      sync1_q <= trig_async;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      if (!sync2_q) armed_q <= 1'b1;
    end
  end

  // Rising edge of the synchronised trigger, only once armed
  always_comb begin
    edge_pulse = armed_q & sync2_q & ~prev_q;
  end

endmodule

// File: rtl/serial_frame_sender.sv
// Trigger-initiated serial frame transmitter: capture payload at a fixed
// delay, shift it out with a framing flag, then hold off further triggers.
//
// Output protocol: dflag qualifies serial_data_out (a bit is meaningful only
// while dflag is high); done and trig_overrun are single-clock pulses; busy is
// a level. There is no backpressure: the frame is emitted unconditionally.
module serial_frame_sender
  import serial_frame_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int LATCH_DLY = DEF_LATCH_DLY,
  parameter int SEND_DLY  = DEF_SEND_DLY,
  parameter int HOLDOFF   = DEF_HOLDOFF,
  parameter int BIT_CYC   = DEF_BIT_CYC,
  parameter int MSB_FIRST = 1,
  parameter int PARITY_EN = 0
) (
  input  logic              Ten_MHz_wire,
  input  logic              reset_n,
  input  logic              sending_trigger_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              serial_data_out,
  output logic              dflag,
  output logic              busy,
  output logic              done,
  output logic              trig_overrun,
  output state_t            state_dbg
);

  localparam int FRAME_W = frame_w(DATA_W, PARITY_EN);
  localparam int CNT_W   = $clog2(HOLDOFF + 1);
  localparam int IDX_W   = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam int SUB_W   = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam int FB_W    = 1 << IDX_W;

  localparam logic [CNT_W-1:0] LATCH_AT = CNT_W'(LATCH_DLY);
  localparam logic [CNT_W-1:0] SEND_AT  = CNT_W'(SEND_DLY);
  localparam logic [CNT_W-1:0] HOLD_AT  = CNT_W'(HOLDOFF);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_W - 1);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(BIT_CYC - 1);

  // Parameter sanity: the timeline must be strictly ordered
  if (DATA_W < 1 || DATA_W > 32) begin : g_bad_width
    $fatal(1, "serial_frame_sender: DATA_W must be 1..32");
  end
  if (BIT_CYC < 1) begin : g_bad_bitcyc
    $fatal(1, "serial_frame_sender: BIT_CYC must be at least 1");
  end
  if (LATCH_DLY >= SEND_DLY) begin : g_bad_latch
    $fatal(1, "serial_frame_sender: LATCH_DLY must be below SEND_DLY");
  end
  if (SEND_DLY + 1 + FRAME_W * BIT_CYC >= HOLDOFF) begin : g_bad_holdoff
    $fatal(1, "serial_frame_sender: frame does not end before HOLDOFF");
  end

  logic trig_edge;

  trigger_edge_sync u_trig (
    .clk        (Ten_MHz_wire),
    .rst_n      (reset_n),
    .trig_async (sending_trigger_in),
    .edge_pulse (trig_edge)
  );

  state_t            state_q,   state_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic [DATA_W-1:0] payload_q, payload_d;
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic [SUB_W-1:0]  sub_q,     sub_d;
  logic              ser_q,     ser_d;
  logic              dflag_q,   dflag_d;
  logic              done_q,    done_d;
  logic              ovr_q,     ovr_d;
  logic [FB_W-1:0]   frame_bits;
  logic [IDX_W-1:0]  idx_next;

  // Frame bits in transmit order: frame_bits[k] is the k-th bit on the wire
  always_comb begin
    frame_bits = '0;
    for (int k = 0; k < DATA_W; k++) begin
      frame_bits[k] = (MSB_FIRST != 0) ? payload_q[DATA_W-1-k] : payload_q[k];
    end
    if (PARITY_EN != 0) frame_bits[FRAME_W-1] = ^payload_q;
  end

  // State, counters, payload and registered outputs
  always_ff @(posedge Ten_MHz_wire or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      payload_q <= '0;
      bit_idx_q <= '0;
      sub_q     <= '0;
      ser_q     <= 1'b0;
      dflag_q   <= 1'b0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      payload_q <= payload_d;
      bit_idx_q <= bit_idx_d;
      sub_q     <= sub_d;
      ser_q     <= ser_d;
      dflag_q   <= dflag_d;
      done_q    <= done_d;
      ovr_q     <= ovr_d;
    end
  end

  // Next-state and next-output logic for the transmit timeline
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    payload_d = payload_q;
    bit_idx_d = bit_idx_q;
    sub_d     = sub_q;
    ser_d     = ser_q;
    dflag_d   = dflag_q;
    done_d    = 1'b0;
    ovr_d     = trig_edge && (state_q != ST_IDLE);
    idx_next  = bit_idx_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        // cnt held at zero; entering WAIT_LATCH with cnt=0 defines t0
        cnt_d = '0;
        if (trig_edge) state_d = ST_WAIT_LATCH;
      end
      ST_WAIT_LATCH: begin
        if (cnt_q == LATCH_AT) begin
          payload_d = data_in;
          state_d   = ST_WAIT_SEND;
        end
      end
      ST_WAIT_SEND: begin
        if (cnt_q == SEND_AT) begin
          state_d   = ST_SHIFT;
          bit_idx_d = '0;
          sub_d     = '0;
          ser_d     = frame_bits[0];
          dflag_d   = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (sub_q == SUB_LAST) begin
          sub_d = '0;
          if (bit_idx_q == IDX_LAST) begin
            bit_idx_d = '0;
            ser_d     = 1'b0;
            dflag_d   = 1'b0;
            done_d    = 1'b1;
            state_d   = ST_HOLDOFF;
          end else begin
            bit_idx_d = idx_next;
            ser_d     = frame_bits[idx_next];
          end
        end else begin
          sub_d = sub_q + 1'b1;
        end
      end
      ST_HOLDOFF: begin
        if (cnt_q == HOLD_AT) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output mapping
  always_comb begin
    serial_data_out = ser_q;
    dflag           = dflag_q;
    busy            = (state_q != ST_IDLE);
    done            = done_q;
    trig_overrun    = ovr_q;
    state_dbg       = state_q;
  end

endmodule
